// File: rtl/decoder_scan.sv
// decoder_scan: registered 1-of-2^SEL_W decoder with active-low strobes,
// active-low enable and an auto-scan mode that walks the strobe across all
// channels every PRESCALE clocks.
// Optional build macro: DECODER_SCAN_BLANK_EN adds break-before-make
// blanking on every scan step (PRESCALE must then be >= 2).
//
// state  | meaning
// -------+-----------------------------------------------------------
// OFF    | G_L high: all strobes blanked, IDX holds, prescaler cleared
// DIRECT | G_L low, MODE low: Y_L/IDX follow SEL one edge later
// SCAN   | G_L low, MODE high: IDX advances every PRESCALE clocks

module decoder_scan #(
  parameter int SEL_W    = 2,
  parameter int PRESCALE = 4
) (
  input  logic                    CLK,
  input  logic                    RESET_L,
  input  logic                    G_L,
  input  logic                    MODE,
  input  logic [SEL_W-1:0]        SEL,
  output logic [(1<<SEL_W)-1:0]   Y_L,
  output logic [SEL_W-1:0]        IDX,
  output logic                    WRAP,
  output logic                    ACTIVE
);

  localparam int N  = 1 << SEL_W;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [SEL_W-1:0] IDX_MAX   = {SEL_W{1'b1}};
  localparam logic [N-1:0]     ALL_OFF   = {N{1'b1}};

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    pcnt;
  logic [SEL_W-1:0] idx_next;

  function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] i);
    logic [N-1:0] d;
    d    = ALL_OFF;
    d[i] = 1'b0;
    return d;
  endfunction

  // Scan index wraps naturally through the SEL_W-bit adder.
  assign idx_next = IDX + SEL_W'(1);

  // Single FSM: state, prescaler and all outputs registered together.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state  <= OFF;
      pcnt   <= '0;
      Y_L    <= ALL_OFF;
      IDX    <= '0;
      WRAP   <= 1'b0;
      ACTIVE <= 1'b0;
    end else if (G_L) begin
      state  <= OFF;
      pcnt   <= '0;
      Y_L    <= ALL_OFF;
      WRAP   <= 1'b0;
      ACTIVE <= 1'b0;
    end else if (!MODE) begin
      state  <= DIRECT;
      pcnt   <= '0;
      Y_L    <= decode(SEL);
      IDX    <= SEL;
      WRAP   <= 1'b0;
      ACTIVE <= 1'b1;
    end else if (state != SCAN) begin
      // Fresh entry always restarts from SEL, even after a one-cycle blank.
      state  <= SCAN;
      pcnt   <= '0;
      Y_L    <= decode(SEL);
      IDX    <= SEL;
      WRAP   <= 1'b0;
      ACTIVE <= 1'b1;
    end else begin
      ACTIVE <= 1'b1;
      if (pcnt == PCNT_LAST) begin
        pcnt <= '0;
        IDX  <= idx_next;
        WRAP <= (IDX == IDX_MAX);
`ifdef DECODER_SCAN_BLANK_EN
        // Break before make: strobe the new channel one edge later.
        Y_L  <= ALL_OFF;
`else
        Y_L  <= decode(idx_next);
`endif
      end else begin
        pcnt <= pcnt + PW'(1);
        WRAP <= 1'b0;
        Y_L  <= decode(IDX);
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: two instances (SEL_W=2/PRESCALE=4
// and SEL_W=3 with a fast prescaler) against an arithmetic reference model
// that derives the scan index from clocks elapsed since scan entry.

module tb_decoder_scan;

  localparam int PS_A = 4;
`ifdef DECODER_SCAN_BLANK_EN
  localparam int PS_B  = 2;
  localparam bit BLANK = 1'b1;
`else
  localparam int PS_B  = 1;
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_l;
  logic       g_l;
  logic       mode;
  logic [2:0] sel;

  logic [3:0] y_a;
  logic [1:0] idx_a;
  logic       wrap_a, active_a;
  logic [7:0] y_b;
  logic [2:0] idx_b;
  logic       wrap_b, active_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(2), .PRESCALE(PS_A)) dut_a (
    .CLK(clk), .RESET_L(rst_l), .G_L(g_l), .MODE(mode), .SEL(sel[1:0]),
    .Y_L(y_a), .IDX(idx_a), .WRAP(wrap_a), .ACTIVE(active_a)
  );

  decoder_scan #(.SEL_W(3), .PRESCALE(PS_B)) dut_b (
    .CLK(clk), .RESET_L(rst_l), .G_L(g_l), .MODE(mode), .SEL(sel),
    .Y_L(y_b), .IDX(idx_b), .WRAP(wrap_b), .ACTIVE(active_b)
  );

  // Reference model: 0 = off, 1 = direct, 2 = scan
  int m_st[2], m_idx[2], m_start[2], m_cnt[2], m_wrap[2];
  int wraps_b = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_idx[k] = 0; m_start[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int n, input int ps);
    int s;
    s = int'(sel) % n;
    m_wrap[k] = 0;
    if (g_l) m_st[k] = 0;
    else if (!mode) begin
      m_st[k] = 1; m_idx[k] = s;
    end else if (m_st[k] != 2) begin
      m_st[k] = 2; m_start[k] = s; m_cnt[k] = 0; m_idx[k] = s;
    end else begin
      m_cnt[k]++;
      m_idx[k] = (m_start[k] + m_cnt[k] / ps) % n;
      if ((m_cnt[k] % ps) == 0 && m_idx[k] == 0) m_wrap[k] = 1;
    end
  endtask

  function automatic logic [31:0] exp_y(input int k, input int n, input int ps);
    logic [31:0] ones;
    ones = (32'd1 << n) - 32'd1;
    if (m_st[k] == 0) return ones;
    if (BLANK && m_st[k] == 2 && m_cnt[k] > 0 && (m_cnt[k] % ps) == 0) return ones;
    return ones & ~(32'd1 << m_idx[k]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("a_y",      32'(y_a),      exp_y(0, 4, PS_A));
    check("a_idx",    32'(idx_a),    32'(m_idx[0]));
    check("a_wrap",   32'(wrap_a),   32'(m_wrap[0]));
    check("a_active", 32'(active_a), 32'(m_st[0] != 0));
    check("b_y",      32'(y_b),      exp_y(1, 8, PS_B));
    check("b_idx",    32'(idx_b),    32'(m_idx[1]));
    check("b_wrap",   32'(wrap_b),   32'(m_wrap[1]));
    check("b_active", 32'(active_b), 32'(m_st[1] != 0));
    check("a_onehot", 32'($countones(~y_a) <= 1), 32'd1);
    check("b_onehot", 32'($countones(~y_b) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_l) model_reset();
    else begin
      model_step(0, 4, PS_A);
      model_step(1, 8, PS_B);
    end
    #1;
    if (m_wrap[1] != 0) wraps_b++;
    check_all();
  endtask

  initial begin
    rst_l = 1'b0; g_l = 1'b1; mode = 1'b0; sel = 3'd0;
    model_reset();
    #12;
    check_all();
    rst_l = 1'b1;
    tick();

    // Direct decode of SEL=2, then blank via G_L.
    g_l = 1'b0; mode = 1'b0; sel = 3'd2;
    tick();
    check("dir_y_literal", 32'(y_a), 32'h0000000B);
    check("dir_idx_literal", 32'(idx_a), 32'd2);
    g_l = 1'b1;
    tick();
    check("off_y_literal", 32'(y_a), 32'h0000000F);
    check("off_active", 32'(active_a), 32'd0);

    // Scan from SEL=3: 3,0,1,2,3 with wrap on 3->0.
    g_l = 1'b0; mode = 1'b1; sel = 3'd3;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 4) begin
        check("scan_wrap_3to0", 32'(wrap_a), 32'd1);
        check("scan_idx0", 32'(idx_a), 32'd0);
      end
      if (i == 6) check("scan_y_idx0", 32'(y_a), 32'h0000000E);
    end

    // Let instance B run a few full cycles; count its wraps.
    wraps_b = 0;
    for (int i = 0; i < 8 * PS_B * 3; i++) tick();
    check("b_wrap_count", 32'(wraps_b), 32'd3);

    // One-cycle G_L blank mid-scan with SEL=1: reload, no wrap.
    sel = 3'd1;
    tick();
    g_l = 1'b1;
    tick();
    check("churn_blank_y", 32'(y_a), 32'h0000000F);
    g_l = 1'b0;
    tick();
    check("churn_reload_idx", 32'(idx_a), 32'd1);
    check("churn_no_wrap", 32'(wrap_a), 32'd0);
    for (int i = 0; i < 6; i++) tick();

    // Asynchronous reset mid-scan, observed before the next edge.
    #2;
    rst_l = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_y_literal", 32'(y_a), 32'h0000000F);
    tick();
    #2;
    rst_l = 1'b1;

    // Randomized churn of enable, mode and select.
    for (int i = 0; i < 600; i++) begin
      g_l  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) sel = 3'($urandom_range(0, 7));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
